// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, widths and shared types.
package des_pkg;
    localparam int KEY_W = 64;
    localparam int CD_W = 56;
    localparam int SK_W = 48;
    localparam int HALF_W = 28;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [SK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Bit 1 is the MSB, so a left shift moves bits toward index 1.
    function automatic logic [1:HALF_W] rot28(input logic [1:HALF_W] x, input logic [1:0] n, input logic right);
        return right ? (x >> n) | (x << (5'd28 - {3'd0, n}))
                     : (x << n) | (x >> (5'd28 - {3'd0, n}));
    endfunction
endpackage

// File: rtl/des_key_sched_if.sv
// des_key_sched_if: key-offer and subkey-issue handshakes of the DES key schedule.
interface des_key_sched_if;
    import des_pkg::*;
    logic key_valid;
    logic key_ready;
    logic [1:KEY_W] key;
    logic decrypt;
    logic subkey_valid;
    logic subkey_ready;
    logic [1:SK_W] subkey;
    logic [3:0] round_idx;
    logic last;

    modport master (
        output key_valid, key, decrypt, subkey_ready,
        input key_ready, subkey_valid, subkey, round_idx, last
    );

    modport slave (
        input key_valid, key, decrypt, subkey_ready,
        output key_ready, subkey_valid, subkey, round_idx, last
    );
endinterface

// File: rtl/des_pc2.sv
// des_pc2: PC-2 selection of the 48-bit round key from C,D.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:CD_W] cd,
    output logic [1:SK_W] subkey
);
    for (genvar i = 0; i < SK_W; i++) begin : g_pc2
        assign subkey[i+1] = cd[PC2[i]];
    end
endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: iterative DES key schedule issuing K1..K16 or K16..K1, one per handshake.
module des_key_sched
    import des_pkg::*;
(
    input logic clk,
    input logic rst_n,
    des_key_sched_if.slave bus
);
    state_t state, state_nx;
    logic [1:HALF_W] c, d, c_nx, d_nx;
    logic [3:0] idx, idx_nx;
    logic dec, dec_nx;
    logic [1:CD_W] pc1_key;
    logic [1:0] amt;

    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign pc1_key[i+1] = bus.key[PC1[i]];
    end

    // Decrypt walks the encrypt schedule backwards with right rotations.
    assign amt = dec ? SHIFTS[~idx] : SHIFTS[idx + 4'd1];

    always_comb begin
        state_nx = state;
        c_nx = c;
        d_nx = d;
        idx_nx = idx;
        dec_nx = dec;
        if (state == IDLE) begin
            if (bus.key_valid) begin
                state_nx = RUN;
                dec_nx = bus.decrypt;
                idx_nx = 4'd0;
                c_nx = bus.decrypt ? pc1_key[1:28] : rot28(pc1_key[1:28], 2'd1, 1'b0);
                d_nx = bus.decrypt ? pc1_key[29:56] : rot28(pc1_key[29:56], 2'd1, 1'b0);
            end
        end else if (bus.subkey_ready) begin
            if (idx == 4'd15) begin
                state_nx = IDLE;
            end else begin
                idx_nx = idx + 4'd1;
                c_nx = rot28(c, amt, dec);
                d_nx = rot28(d, amt, dec);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            c <= '0;
            d <= '0;
            idx <= '0;
            dec <= 1'b0;
        end else begin
            state <= state_nx;
            c <= c_nx;
            d <= d_nx;
            idx <= idx_nx;
            dec <= dec_nx;
        end
    end

    assign bus.key_ready = state == IDLE;
    assign bus.subkey_valid = state == RUN;
    assign bus.round_idx = idx;
    assign bus.last = (state == RUN) && (idx == 4'd15);

    des_pc2 u_pc2 (.cd({c, d}), .subkey(bus.subkey));
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: directed checks of the DES key schedule against the published K1..K16 of a known key.
module tb_des_key_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    des_key_sched_if bus();
    des_key_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    // Same key with every parity bit flipped, so it yields the same subkeys.
    localparam logic [63:0] KEY2 = 64'h123556789ABDDEF0;

    logic [47:0] ek [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " key_ready"}, 64'(bus.key_ready), 64'd1);
        chk({tag, " subkey_valid"}, 64'(bus.subkey_valid), 64'd0);
        chk({tag, " last"}, 64'(bus.last), 64'd0);
    endtask

    task automatic check_sub(input string tag, input int i, input logic dc);
        string t;
        t = $sformatf("%s #%0d", tag, i);
        chk({t, " subkey_valid"}, 64'(bus.subkey_valid), 64'd1);
        chk({t, " key_ready"}, 64'(bus.key_ready), 64'd0);
        chk({t, " subkey"}, 64'(bus.subkey), 64'(dc ? ek[15-i] : ek[i]));
        chk({t, " round_idx"}, 64'(bus.round_idx), 64'(i));
        chk({t, " last"}, 64'(bus.last), 64'(i == 15));
    endtask

    task automatic run_seq(input string tag, input logic dc);
        for (int i = 0; i < 16; i++) begin
            check_sub(tag, i, dc);
            tick;
        end
        check_idle({tag, " end"});
    endtask

    task automatic offer(input logic [63:0] k, input logic dc);
        bus.key = k;
        bus.decrypt = dc;
        bus.key_valid = 1'b1;
        tick;
        bus.key_valid = 1'b0;
    endtask

    initial begin
        int hs;
        int cyc;
        logic rdy;
        bus.key_valid = 1'b0;
        bus.key = '0;
        bus.decrypt = 1'b0;
        bus.subkey_ready = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check_idle("reset");
        chk("reset round_idx", 64'(bus.round_idx), 64'd0);
        chk("reset subkey", 64'(bus.subkey), 64'd0);

        bus.subkey_ready = 1'b1;
        offer(KEY1, 1'b0);
        run_seq("enc", 1'b0);
        offer(KEY1, 1'b1);
        run_seq("dec", 1'b1);

        offer(KEY1, 1'b0);
        hs = 0;
        cyc = 0;
        while (hs < 16 && cyc < 200) begin
            check_sub("stall", hs, 1'b0);
            rdy = 1'($urandom_range(0, 1));
            bus.subkey_ready = rdy;
            tick;
            if (rdy) hs++;
            cyc++;
        end
        chk("stall handshakes", 64'(hs), 64'd16);
        check_idle("stall end");

        bus.subkey_ready = 1'b1;
        offer(KEY1, 1'b0);
        for (int i = 0; i < 7; i++) tick;
        chk("mid round_idx", 64'(bus.round_idx), 64'd7);
        rst_n = 1'b0;
        tick;
        check_idle("midrst");
        chk("midrst round_idx", 64'(bus.round_idx), 64'd0);
        chk("midrst subkey", 64'(bus.subkey), 64'd0);
        rst_n = 1'b1;
        tick;
        check_idle("midrst held");
        offer(KEY1, 1'b1);
        run_seq("fresh", 1'b1);

        bus.key = KEY1;
        bus.decrypt = 1'b0;
        bus.key_valid = 1'b1;
        tick;
        bus.key = KEY2;
        bus.decrypt = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_sub("busy", i, 1'b0);
            tick;
        end
        check_idle("busy end");
        tick;
        bus.key_valid = 1'b0;
        run_seq("key2", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/des_key_sched.md
# des_key_sched

Iterative DES key schedule that turns one 64-bit key into the sixteen 48-bit round subkeys, one per handshake. It runs in encrypt order (K1..K16, left rotations) or decrypt order (K16..K1, right rotations). It sits beside the round datapath, after the E expansion and before the key-XOR. The decrypt mode is the reverse-direction counterpart of the encrypt path, so one engine serves both ciphers.

## Interface
- No parameters; all widths are fixed by the DES standard.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `key_valid` input 1: the key and mode offer is valid.
- `key_ready` output 1: the engine is idle and accepts a key.
- `key` input [1:64]: DES key, bit 1 = MSB, parity bits 8,16,…,64 ignored.
- `decrypt` input 1: sampled with `key`; 0 = K1→K16, 1 = K16→K1.
- `subkey_valid` output 1: `subkey` holds a valid round key.
- `subkey_ready` input 1: the round datapath consumes `subkey`.
- `subkey` output [1:48]: current round key, DES bit order.
- `round_idx` output [3:0]: 0..15, ordinal of the subkey in the issued sequence (not the Kn number).
- `last` output 1: high with `subkey_valid` when `round_idx`=15.

## Operation
- State machine has two states, IDLE and RUN.
- **IDLE**
  - `key_ready`=1, `subkey_valid`=0.
  - On `key_valid && key_ready`, the engine loads C,D = PC-1(`key`) (28+28 bits), latches `decrypt`, clears `round_idx`, and moves to RUN.
  - Encrypt load: C,D are stored already rotated left by 1, so the first subkey is K1.
  - Decrypt load: C,D are stored unrotated. The total left shift is 28 (identity), so the first subkey is K16.
- **RUN**
  - Outputs: `subkey_valid`=1, `key_ready`=0, `subkey` = PC-2(C,D), taken combinationally from the C,D registers.
  - On each `subkey_valid && subkey_ready`, `round_idx` increments and C,D rotate by the schedule amount for the next step.
  - Encrypt steps use left rotations of 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; entry 0 is consumed at load.
  - Decrypt steps use right rotations of 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, applied after `round_idx` 0..14.
  - C and D rotate independently within 28 bits (wrap-around).
- **Exit:** a handshake with `round_idx`=15 returns the engine to IDLE. C,D and `round_idx` hold their values; they do not matter in IDLE.
- **Backpressure:** while `subkey_ready`=0, `subkey`, `round_idx` and `last` hold stable.
- **Reset values:** `key_ready`=1, `subkey_valid`=0, `last`=0, `round_idx`=0, C=D=0, and therefore `subkey`=0. State = IDLE.
- **Reset mid-sequence:** the engine abandons the sequence and returns to IDLE on the next edge with reset values. No partial output follows.
- **New key while in RUN:** `key_ready`=0, so the key is not accepted and `key_valid` is ignored until the engine is back in IDLE.
- **Simultaneous events:** the final subkey handshake and a new `key_valid` cannot accept in the same cycle. The new key is accepted no earlier than the cycle after IDLE is entered.

## Timing
- Key accepted on edge N, so `subkey_valid`=1 with the first subkey after edge N.
- One subkey per cycle with `subkey_ready` held high. The 16th handshake lands on edge N+16, and `key_ready`=1 after it.
- Minimum key-to-key period is 17 cycles.
- `subkey` is a function of registered C,D through one PC-2 permutation (wiring only), with no added latency.
- All outputs are registers or pure wiring of registers; nothing is combinational from inputs to outputs.

## Structure
- Package `des_pkg` holds:
  - PC-1 and PC-2 tables;
  - the 16-entry shift schedule;
  - localparams for widths 64/56/48/28.
- Sub-module `des_pc2`: combinational 56→48 bit selection in the same `[1:N]` DES bit-order style as the E expansion, instantiated once.
- PC-1 is applied inline at load.
- The rotation amount is selected by `round_idx` and `decrypt`.

## Test plan
- Reset, then check `key_ready`=1, `subkey_valid`=0, `round_idx`=0, `subkey`=0.
- Encrypt with key 0x133457799BBCDFF1 and `subkey_ready`=1: first `subkey`=0x1B02EFFC7072 at `round_idx` 0, and the 16th `subkey`=0xCB3D8B0E17F5 with `last`=1.
- Decrypt with the same key: first `subkey`=0xCB3D8B0E17F5, 16th `subkey`=0x1B02EFFC7072. The whole sequence equals the encrypt sequence reversed.
- Random `subkey_ready` stalls: `subkey` and `round_idx` hold while stalled, and exactly 16 handshakes occur per key.
- Assert `rst_n`=0 at `round_idx`=7, then release: engine is IDLE with reset values. A fresh key restarts cleanly from `round_idx` 0.
- Assert `key_valid` throughout RUN with a different key: it is ignored, the sequence completes for the first key, and the second key is accepted one cycle after IDLE.
